// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/execute controller for an RV32C core.
// Owns the PC, fetches one halfword per instruction over a valid/ready
// instruction-memory handshake, and executes the subset C.ADDI (incl. C.NOP),
// C.LI and C.J. Stops in HALT on an illegal encoding or a fetch timeout.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   imem_req/imem_addr      fetch request (held until accepted) and address (=pc)
//   imem_ready/imem_data    memory accept strobe and instruction halfword
//   rf_select/rf_rdata      register index and combinational read data
//   rf_we/rf_wdata          register write strobe and write data
//   pc                      current program counter
//   halted/halt_cause       stop flag; cause 0 none, 1 illegal, 2 fetch timeout
//   retired                 legal-instruction count (optional, see below)
//
// Optional feature: define CPU_SEQUENCER_RETIRE_COUNT_EN to add the 32-bit
// `retired` output counting every legal instruction executed since reset.
module cpu_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned WAIT_LIMIT = 15      // 1..255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [4:0]  rf_select,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  halt_cause
`ifdef CPU_SEQUENCER_RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [7:0] WAIT_LIM = WAIT_LIMIT[7:0];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        halted_q, halted_d;
  logic [1:0]  cause_q, cause_d;

  // Decode of the latched instruction.
  logic        is_addi, is_li, is_j, legal;
  logic [4:0]  rd;
  logic [31:0] imm6, joff;
  logic [7:0]  wait_inc;

  assign rd      = ir_q[11:7];
  assign is_addi = (ir_q[15:13] == 3'b000) && (ir_q[1:0] == 2'b01);
  assign is_li   = (ir_q[15:13] == 3'b010) && (ir_q[1:0] == 2'b01);
  assign is_j    = (ir_q[15:13] == 3'b101) && (ir_q[1:0] == 2'b01);
  assign legal   = is_addi || is_li || is_j;
  assign imm6    = {{26{ir_q[12]}}, ir_q[12], ir_q[6:2]};
  // C.J scatters offset bits: ir[12:2] = off[11|4|9:8|10|6|7|3:1|5].
  assign joff    = {{20{ir_q[12]}}, ir_q[12], ir_q[8], ir_q[10:9], ir_q[6],
                    ir_q[7], ir_q[2], ir_q[11], ir_q[5:3], 1'b0};
  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'd0;
      wait_q   <= 8'd0;
      halted_q <= 1'b0;
      cause_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      wait_q   <= wait_d;
      halted_q <= halted_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    halted_d  = halted_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    rf_select = 5'd0;
    rf_we     = 1'b0;
    rf_wdata  = 32'd0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_data;
          wait_d  = 8'd0;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_inc;
          // wait_inc counts this cycle, so the limit-th stall halts now.
          if (wait_inc == WAIT_LIM) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            cause_d  = 2'd2;
          end
        end
      end
      S_EXEC: begin
        rf_select = rd;
        if (is_addi || is_li) begin
          rf_wdata = is_addi ? (rf_rdata + imm6) : imm6;
          rf_we    = (rd != 5'd0);
          pc_d     = pc_q + 32'd2;
          state_d  = S_FETCH;
        end else if (is_j) begin
          pc_d    = pc_q + joff;
          state_d = S_FETCH;
        end else begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = 2'd1;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
    // Reset must not let a pending fetch or exec leak onto the buses.
    if (reset) begin
      imem_req  = 1'b0;
      rf_select = 5'd0;
      rf_we     = 1'b0;
      rf_wdata  = 32'd0;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign halt_cause = cause_q;

`ifdef CPU_SEQUENCER_RETIRE_COUNT_EN
  logic [31:0] retired_q;
  always_ff @(posedge clock) begin
    if (reset)                           retired_q <= 32'd0;
    else if (state_q == S_EXEC && legal) retired_q <= retired_q + 32'd1;
  end
  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer. The driver acts as the
// instruction memory and runs an ISA-level model that predicts fetch
// addresses, register writes and halts; a negedge monitor compares them.
module tb_cpu_sequencer;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;  // wraps after a few instrs
  localparam int WL = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, rf_we, halted;
  logic [31:0] imem_addr, rf_rdata, rf_wdata, pc;
  logic [15:0] imem_data;
  logic [4:0]  rf_select;
  logic [1:0]  halt_cause;
`ifdef CPU_SEQUENCER_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  cpu_sequencer #(.RESET_PC(RESET_PC), .WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .rf_select(rf_select), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_wdata(rf_wdata),
    .pc(pc), .halted(halted), .halt_cause(halt_cause)
`ifdef CPU_SEQUENCER_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clock = ~clock;

  // Environment register file.
  logic [31:0] seedv [32];
  logic [31:0] regs  [32];
  logic        init_go;
  assign rf_rdata = regs[rf_select];
  always @(posedge clock) begin
    if (init_go) for (int i = 0; i < 32; i++) regs[i] <= seedv[i];
    else if (rf_we) regs[rf_select] <= rf_wdata;
  end

  typedef struct packed { logic [4:0] idx; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] pc; logic [1:0] cause; } hl_t;
  logic [31:0] fq[$];
  wr_t         wq[$];
  hl_t         hq[$];
  logic [15:0] dq[$];   // directed instructions, used before random ones
  int          sq[$];   // directed stall counts

  int n_vec = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on observed DUT activity.
  bit halt_seen = 1'b0;
  always @(negedge clock) begin
    wr_t e;
    hl_t h;
    if (reset) halt_seen = 1'b0;
    else begin
      check("imem_addr==pc", imem_addr, pc);
      if (imem_req) begin
        if (fq.size() == 0) check("unexpected fetch", 32'(imem_req), 32'd0);
        else begin
          check("fetch addr", imem_addr, fq[0]);
          if (imem_ready) void'(fq.pop_front());
        end
      end
      if (rf_we) begin
        if (wq.size() == 0) check("unexpected rf_we", 32'(rf_we), 32'd0);
        else begin
          e = wq.pop_front();
          check("rf_select", 32'(rf_select), 32'(e.idx));
          check("rf_wdata", rf_wdata, e.data);
        end
      end
      if (halted) begin
        check("halt imem_req", 32'(imem_req), 32'd0);
        if (!halt_seen) begin
          halt_seen = 1'b1;
          if (hq.size() == 0) check("unexpected halt", 32'(halted), 32'd0);
          else begin
            h = hq.pop_front();
            check("halt pc", pc, h.pc);
            check("halt cause", 32'(halt_cause), 32'(h.cause));
          end
        end
      end else if (halt_seen) check("halt dropped", 32'(halted), 32'd1);
    end
  end

  // ISA-level model state.
  logic [31:0] mregs [32];
  logic [31:0] mpc, mret;

  function automatic bit is_legal(input logic [15:0] x);
    return x[1:0] == 2'b01 && (x[15:13] == 3'b000 || x[15:13] == 3'b010 || x[15:13] == 3'b101);
  endfunction

  function automatic logic [15:0] gen_instr();
    int r = $urandom_range(0, 99);
    logic [4:0]  rd = 5'($urandom);
    logic [5:0]  im = 6'($urandom);
    logic [10:0] jb = 11'($urandom);
    logic [15:0] x  = 16'($urandom);
    if (r < 40) return {3'b000, im[5], rd, im[4:0], 2'b01};
    if (r < 65) return {3'b010, im[5], rd, im[4:0], 2'b01};
    if (r < 93) return {3'b101, jb, 2'b01};
    if (r < 95) return 16'h0000;
    if (is_legal(x)) x[1:0] = 2'b10;
    return x;
  endfunction

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    imem_ready = 1'($urandom);
    imem_data  = 16'($urandom);
    fq.delete(); wq.delete(); hq.delete();
    repeat (cycles) begin
      @(negedge clock);
      check("rst imem_req", 32'(imem_req), 32'd0);
      check("rst rf_we", 32'(rf_we), 32'd0);
      check("rst rf_select", 32'(rf_select), 32'd0);
      check("rst rf_wdata", rf_wdata, 32'd0);
      @(posedge clock); #1;
    end
    check("rst pc", pc, RESET_PC);
    check("rst halted", 32'(halted), 32'd0);
    check("rst halt_cause", 32'(halt_cause), 32'd0);
    reset = 1'b0;
    imem_ready = 1'b0;
    mpc = RESET_PC;
    mret = 32'd0;
  endtask

  task automatic halt_tail(input logic [1:0] cause);
    repeat (3) begin
      imem_ready = 1'($urandom);
      imem_data  = 16'($urandom);
      @(posedge clock); #1;
      check("halt hold pc", pc, mpc);
      check("halt hold halted", 32'(halted), 32'd1);
      check("halt hold cause", 32'(halt_cause), 32'(cause));
    end
    imem_ready = 1'b0;
  endtask

  task automatic end_checks();
    for (int i = 0; i < 32; i++) check($sformatf("x%0d", i), regs[i], mregs[i]);
    check("halt not seen", 32'(hq.size()), 32'd0);
    check("writes not seen", 32'(wq.size()), 32'd0);
`ifdef CPU_SEQUENCER_RETIRE_COUNT_EN
    check("retired", retired, mret);
`endif
  endtask

  task automatic run_episode(input int n_instr);
    logic [15:0] ir;
    logic signed [5:0]  s6;
    logic signed [11:0] off;
    logic [31:0] npc, wv;
    int  stalls;
    bit  lg, wr;
    do_reset(1 + $urandom_range(0, 1));
    for (int i = 0; i < n_instr; i++) begin
      ir = (dq.size() != 0) ? dq.pop_front() : gen_instr();
      if (sq.size() != 0) stalls = sq.pop_front();
      else begin
        stalls = $urandom_range(0, 99);
        stalls = (stalls < 60) ? 0 : (stalls < 97) ? $urandom_range(1, WL - 1) : WL;
      end
      fq.push_back(mpc);
      if (stalls >= WL) begin
        hq.push_back('{pc: mpc, cause: 2'd2});
        imem_ready = 1'b0;
        repeat (WL) begin imem_data = 16'($urandom); @(posedge clock); #1; end
        halt_tail(2'd2);
        end_checks();
        return;
      end
      imem_ready = 1'b0;
      repeat (stalls) begin imem_data = 16'($urandom); @(posedge clock); #1; end
      imem_ready = 1'b1;
      imem_data  = ir;
      // Model the instruction from its architectural definition.
      lg  = is_legal(ir);
      wr  = 1'b0;
      wv  = 32'd0;
      npc = mpc;
      s6  = {ir[12], ir[6:2]};
      off = {ir[12], ir[8], ir[10:9], ir[6], ir[7], ir[2], ir[11], ir[5:3], 1'b0};
      if (!lg) hq.push_back('{pc: mpc, cause: 2'd1});
      else if (ir[15:13] == 3'b101) npc = mpc + 32'(off);
      else begin
        npc = mpc + 32'd2;
        wv  = (ir[15:13] == 3'b000) ? mregs[ir[11:7]] + 32'(s6) : 32'(s6);
        wr  = (ir[11:7] != 5'd0);
        if (wr) wq.push_back('{idx: ir[11:7], data: wv});
      end
      @(posedge clock); #1;
      imem_ready = 1'b0;
      imem_data  = 16'($urandom);
      if (lg && $urandom_range(0, 19) == 0) begin
        do_reset(1);   // abort mid-exec: nothing commits
        continue;
      end
      @(posedge clock); #1;
      if (!lg) begin
        halt_tail(2'd1);
        end_checks();
        return;
      end
      if (wr) mregs[ir[11:7]] = wv;
      mpc  = npc;
      mret = mret + 32'd1;
    end
    end_checks();
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0;
    imem_data = 16'd0;
    init_go = 1'b0;
    for (int i = 0; i < 32; i++) begin
      seedv[i] = (i == 0) ? 32'd0 : $urandom;
      mregs[i] = seedv[i];
    end
    init_go = 1'b1;
    @(posedge clock); #1;
    init_go = 1'b0;
    // ADDI x1,5; LI x2,-1; ADDI x1,5; J +4; J 0 (self loop) x2; illegal 0.
    dq = '{16'h0095, 16'h517D, 16'h0095, 16'hA011, 16'hA001, 16'hA001, 16'h0000};
    sq = '{0, 0, 0, 0, 0, 0, 0};
    run_episode(10);
    // Stall just under the limit, then exactly at it.
    dq = '{16'h0095};
    sq = '{WL - 1, WL};
    run_episode(5);
    for (int ep = 0; ep < 40; ep++) run_episode($urandom_range(5, 25));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
